dino_input_cond: RTL and testbench
==================================

# dino_input_cond

Input conditioning stage directly upstream of the dino game core: takes the raw, asynchronous jump/halt/debug pad inputs from the user IO pins and delivers synchronised, debounced levels plus a single-cycle jump event to `dinogame`. Runs in the Wishbone clock domain; one instance per game. It also keeps a wrap-around jump press counter for logic-analyzer debug.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles required to accept a level change; legal range 1 to 2^24-1.
- `ACTIVE_LOW`, 0: 1 inverts all three pins before synchronisation, for pull-up buttons.

Ports (all outputs registered):
- `clk`  in  1  sole clock, driven from `wb_clk_i`.
- `sys_rst`  in  1  synchronous, active-high reset.
- `jump_pin`  in  1  raw asynchronous pad input.
- `halt_pin`  in  1  raw asynchronous pad input.
- `debug_pin`  in  1  raw asynchronous pad input.
- `jump_level`  out  1  debounced jump level, drives `dinogame.jump_in`.
- `jump_pulse`  out  1  one-cycle strobe on each debounced jump rising edge.
- `halt_out`  out  1  drives `dinogame.halt_in`.
- `debug_out`  out  1  debounced debug level, drives `dinogame.debug_in`.
- `jump_count`  out  8  count of accepted jump presses.

## Operation
- Per channel, apply polarity (`ACTIVE_LOW`), then a 2-FF synchroniser giving `sync`.
- Per channel, debounce state is `stable` (1 bit) plus `cnt` (24 bits).
  - If `sync == stable`: `cnt <= 0`.
  - If `sync != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= sync` and `cnt <= 0`.
  - Otherwise `cnt <= cnt + 1`.
- Any glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count and is never seen on the outputs.
- `jump_level` and `debug_out` equal their channel's `stable`.
- `jump_pulse` is 1 for exactly the cycle after jump `stable` goes 0->1. It does not fire on release.
- `jump_count` increments on each `jump_pulse` and wraps from 255 to 0. It does not saturate.
- `halt_out` equals halt `stable` (level mode); see Configuration for toggle mode.
- Reset value of every output, `sync` FF, `stable` and `cnt` is 0.
- Reset mid-debounce discards the partial count.
- A pin held active through reset is treated as a fresh press after reset release. It is accepted after the full latency and produces one `jump_pulse`.

## Timing
- Latency from pin edge to `stable`/level outputs: 2 (sync) + `DEBOUNCE_CYCLES` cycles.
- `jump_pulse` and the `jump_count` update follow one cycle after `jump_level` rises.
- With `DEBOUNCE_CYCLES`=1, a change is accepted on the first cycle `sync` differs from `stable`.
- Channels are fully independent. Simultaneous changes on all three pins resolve in the same cycle.
- Minimum press-to-press spacing for distinct pulses is 2x(`DEBOUNCE_CYCLES`). A release must itself be accepted before the next press can be.

## Configuration
- `DINO_HALT_TOGGLE_EN` defined:
  - `halt_out` is a toggle flop, reset to 0.
  - It inverts on each debounced halt rising edge, one cycle after halt `stable` rises.
  - A single press pauses the game; the next press resumes it.
- Not defined: `halt_out` = halt `stable` (hold-to-pause), and the toggle flop is not built.

## Structure
- Shared package `dino_pkg`:
  - Channel index constants `DINO_CH_JUMP`=0, `DINO_CH_HALT`=1, `DINO_CH_DEBUG`=2 and `DINO_NUM_CH`=3.
  - `DINO_DBNC_W`=24 counter width.
- Sub-module `dino_debounce_chan`: polarity, synchroniser, debounce counter and `stable` for one channel, plus a rise strobe output. Instantiated `DINO_NUM_CH` times.
- The top of `dino_input_cond` holds the pulse/counter logic and the halt toggle.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `ACTIVE_LOW`=0.
- Reset with all pins at 0 -> every output 0; `jump_count`=0.
- `jump_pin` 0->1 held 10 cycles -> `jump_level` rises 6 cycles after the edge; `jump_pulse` high exactly 1 cycle on the next cycle; `jump_count`=1.
- `jump_pin` 3-cycle high glitch, repeated 5 times with 1-cycle lows between -> `jump_level` stays 0; no pulse; `jump_count` unchanged.
- 256 clean presses -> `jump_count` wraps to 0; pulses 255 and 256 each last one cycle.
- `halt_pin` two clean presses:
  - With `DINO_HALT_TOGGLE_EN`: `halt_out` goes 1 after the first press and 0 after the second, independent of release.
  - Without it: `halt_out` follows the debounced level.
- `jump_pin` held high, `sys_rst` asserted 2 cycles mid-press -> outputs clear to 0; 6 cycles after release `jump_level`=1; exactly one new `jump_pulse`.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared constants for the dino game input conditioning: channel indices and
// debounce counter width.
package dino_pkg;

   localparam int DINO_CH_JUMP  = 0;
   localparam int DINO_CH_HALT  = 1;
   localparam int DINO_CH_DEBUG = 2;
   localparam int DINO_NUM_CH   = 3;
   localparam int DINO_DBNC_W   = 24;

   typedef logic [DINO_DBNC_W-1:0] dino_cnt_t;

endpackage

// File: rtl/dino_debounce_chan.sv
// One input channel: polarity, 2-FF synchroniser, stable-count debouncer and a
// registered strobe that marks the cycle in which stable rises.
module dino_debounce_chan
   import dino_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter bit          ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic sys_rst,
   input  logic pin_i,
   output logic stable_o,
   output logic rise_o
);

   localparam dino_cnt_t CNT_TC = dino_cnt_t'(DEBOUNCE_CYCLES - 1);

   logic      sync1_q, sync2_q;
   logic      stable_q, stable_d;
   logic      rise_q;
   dino_cnt_t cnt_q, cnt_d;

   // Any return to the stable level restarts the count, so glitches never reach stable.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync2_q == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_TC) begin
         stable_d = sync2_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + dino_cnt_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
      end else begin
         sync1_q  <= pin_i ^ ACTIVE_LOW;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         rise_q   <= stable_d & ~stable_q;
      end
   end

   assign stable_o = stable_q;
   assign rise_o   = rise_q;

endmodule

// File: rtl/dino_input_cond.sv
// Input conditioning for the dino game core: debounced jump/halt/debug levels,
// jump strobe and wrap-around press counter. DINO_HALT_TOGGLE_EN selects toggle halt.
module dino_input_cond
   import dino_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter bit          ACTIVE_LOW      = 1'b0
) (
   input  logic       clk,
   input  logic       sys_rst,
   input  logic       jump_pin,
   input  logic       halt_pin,
   input  logic       debug_pin,
   output logic       jump_level,
   output logic       jump_pulse,
   output logic       halt_out,
   output logic       debug_out,
   output logic [7:0] jump_count
);

   logic [DINO_NUM_CH-1:0] pins;
   logic [DINO_NUM_CH-1:0] stable;
   logic [DINO_NUM_CH-1:0] rise;

   assign pins[DINO_CH_JUMP]  = jump_pin;
   assign pins[DINO_CH_HALT]  = halt_pin;
   assign pins[DINO_CH_DEBUG] = debug_pin;

   for (genvar g = 0; g < DINO_NUM_CH; g++) begin : g_chan
      dino_debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_chan (
         .clk      (clk),
         .sys_rst  (sys_rst),
         .pin_i    (pins[g]),
         .stable_o (stable[g]),
         .rise_o   (rise[g])
      );
   end

   logic       jump_pulse_q;
   logic [7:0] jump_count_q;

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         jump_pulse_q <= 1'b0;
         jump_count_q <= 8'd0;
      end else begin
         jump_pulse_q <= rise[DINO_CH_JUMP];
         if (rise[DINO_CH_JUMP]) jump_count_q <= jump_count_q + 8'd1;
      end
   end

   assign jump_level = stable[DINO_CH_JUMP];
   assign debug_out  = stable[DINO_CH_DEBUG];
   assign jump_pulse = jump_pulse_q;
   assign jump_count = jump_count_q;

`ifdef DINO_HALT_TOGGLE_EN
   logic halt_q;

   always_ff @(posedge clk) begin
      if (sys_rst)                 halt_q <= 1'b0;
      else if (rise[DINO_CH_HALT]) halt_q <= ~halt_q;
   end

   assign halt_out = halt_q;

   logic unused_rise;
   assign unused_rise = rise[DINO_CH_DEBUG];
`else
   assign halt_out = stable[DINO_CH_HALT];

   logic unused_rise;
   assign unused_rise = rise[DINO_CH_DEBUG] | rise[DINO_CH_HALT];
`endif

endmodule

// File: tb/tb_dino_input_cond.sv
// Directed bench for dino_input_cond with DEBOUNCE_CYCLES=4, ACTIVE_LOW=0.
// Expected halt behaviour follows DINO_HALT_TOGGLE_EN.
module tb_dino_input_cond;

   logic       clk = 1'b0;
   logic       sys_rst;
   logic       jump_pin, halt_pin, debug_pin;
   logic       jump_level, jump_pulse, halt_out, debug_out;
   logic [7:0] jump_count;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dino_input_cond #(
      .DEBOUNCE_CYCLES (4),
      .ACTIVE_LOW      (1'b0)
   ) dut (
      .clk        (clk),
      .sys_rst    (sys_rst),
      .jump_pin   (jump_pin),
      .halt_pin   (halt_pin),
      .debug_pin  (debug_pin),
      .jump_level (jump_level),
      .jump_pulse (jump_pulse),
      .halt_out   (halt_out),
      .debug_out  (debug_out),
      .jump_count (jump_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Clean press: 16 cycles high, 16 low; returns how many cycles jump_pulse was high.
   task automatic jump_press(output int pulses);
      pulses = 0;
      jump_pin = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (jump_pulse === 1'b1) pulses++;
      end
      jump_pin = 1'b0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (jump_pulse === 1'b1) pulses++;
      end
   endtask

   task automatic halt_press(input logic exp_after_press, input logic exp_after_release);
      halt_pin = 1'b1;
      repeat (8) tick();
      check("halt_after_press", halt_out, exp_after_press);
      halt_pin = 1'b0;
      repeat (8) tick();
      check("halt_after_release", halt_out, exp_after_release);
   endtask

   initial begin
      int pulses;
      int max_level;
      logic toggle_mode;
`ifdef DINO_HALT_TOGGLE_EN
      toggle_mode = 1'b1;
`else
      toggle_mode = 1'b0;
`endif
      sys_rst   = 1'b1;
      jump_pin  = 1'b0;
      halt_pin  = 1'b0;
      debug_pin = 1'b0;
      repeat (3) tick();
      check("rst_jump_level", jump_level, 0);
      check("rst_jump_pulse", jump_pulse, 0);
      check("rst_halt_out",   halt_out,   0);
      check("rst_debug_out",  debug_out,  0);
      check("rst_jump_count", jump_count, 0);
      sys_rst = 1'b0;
      tick();

      // Single press: level at edge 6 after the pin edge, pulse at edge 7.
      jump_pin = 1'b1;
      repeat (5) tick();
      check("press_level_edge5", jump_level, 0);
      tick();
      check("press_level_edge6", jump_level, 1);
      check("press_pulse_edge6", jump_pulse, 0);
      check("press_count_edge6", jump_count, 0);
      tick();
      check("press_pulse_edge7", jump_pulse, 1);
      check("press_count_edge7", jump_count, 1);
      tick();
      check("press_pulse_edge8", jump_pulse, 0);
      repeat (2) tick();
      jump_pin = 1'b0;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (jump_pulse === 1'b1) pulses++;
      end
      check("release_level", jump_level, 0);
      check("release_no_pulse", pulses, 0);
      repeat (4) tick();

      // Glitches of 3 high cycles separated by single low cycles never get through.
      pulses = 0;
      max_level = 0;
      for (int g = 0; g < 5; g++) begin
         jump_pin = 1'b1;
         for (int i = 0; i < 3; i++) begin
            tick();
            if (jump_pulse === 1'b1) pulses++;
            if (jump_level === 1'b1) max_level = 1;
         end
         jump_pin = 1'b0;
         tick();
         if (jump_pulse === 1'b1) pulses++;
         if (jump_level === 1'b1) max_level = 1;
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         if (jump_pulse === 1'b1) pulses++;
         if (jump_level === 1'b1) max_level = 1;
      end
      check("glitch_level", max_level, 0);
      check("glitch_pulses", pulses, 0);
      check("glitch_count", jump_count, 1);

      // 255 more presses bring the total to 256 and wrap the counter.
      for (int p = 2; p <= 256; p++) begin
         jump_press(pulses);
         if (p >= 255) check($sformatf("wrap_press%0d_pulse_width", p), pulses, 1);
         else if (p == 100) check("press100_pulse_width", pulses, 1);
         if (p == 255) check("count_at_255", jump_count, 255);
      end
      check("count_wrapped", jump_count, 0);

      // Halt: level mode follows the pin; toggle mode flips on each press.
      halt_press(1'b1, toggle_mode ? 1'b1 : 1'b0);
      halt_press(toggle_mode ? 1'b0 : 1'b1, 1'b0);
      check("halt_jump_untouched", jump_count, 0);

      // Jump and debug change together and resolve on the same edge.
      jump_pin  = 1'b1;
      debug_pin = 1'b1;
      repeat (5) tick();
      check("simul_jump_edge5",  jump_level, 0);
      check("simul_debug_edge5", debug_out,  0);
      tick();
      check("simul_jump_edge6",  jump_level, 1);
      check("simul_debug_edge6", debug_out,  1);
      check("simul_halt_quiet",  halt_out,   0);
      tick();
      check("simul_pulse",  jump_pulse, 1);
      check("simul_count",  jump_count, 1);
      debug_pin = 1'b0;
      repeat (6) tick();
      check("debug_release", debug_out, 0);
      check("jump_still_held", jump_level, 1);

      // Reset mid-press with the pin held: fresh press after release.
      sys_rst = 1'b1;
      repeat (2) tick();
      check("midrst_level", jump_level, 0);
      check("midrst_count", jump_count, 0);
      check("midrst_pulse", jump_pulse, 0);
      sys_rst = 1'b0;
      repeat (5) tick();
      check("postrst_level_edge5", jump_level, 0);
      tick();
      check("postrst_level_edge6", jump_level, 1);
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (jump_pulse === 1'b1) pulses++;
      end
      check("postrst_pulses", pulses, 1);
      check("postrst_count", jump_count, 1);
      jump_pin = 1'b0;
      repeat (8) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
